// File: rtl/restart_record_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : restart_record_reader_if
// Brief    : Request/status and TPSRAM port bundle for restart_record_reader.
// Revision : 1.0
// ============================================================================
interface restart_record_reader_if;
   logic       i_start;
   logic       o_busy;
   logic       o_done;
   logic       o_valid;
   logic [7:0] o_status;
   logic [7:0] o_image_idx;
   logic [7:0] o_restart_cnt;
   logic [5:0] o_TPSRAM_RADDR_sv;
   logic       o_TPSRAM_REN;
   logic [7:0] i_TPSRAM_RD_sv;
   logic [5:0] o_TPSRAM_WADDR_sv;
   logic [7:0] o_TPSRAM_WD;
   logic       o_TPSRAM_WEN;

   // slave: the reader itself
   modport slave (
      input  i_start, i_TPSRAM_RD_sv,
      output o_busy, o_done, o_valid, o_status, o_image_idx, o_restart_cnt,
             o_TPSRAM_RADDR_sv, o_TPSRAM_REN,
             o_TPSRAM_WADDR_sv, o_TPSRAM_WD, o_TPSRAM_WEN
   );

   // master: requester plus RAM side
   modport master (
      output i_start, i_TPSRAM_RD_sv,
      input  o_busy, o_done, o_valid, o_status, o_image_idx, o_restart_cnt,
             o_TPSRAM_RADDR_sv, o_TPSRAM_REN,
             o_TPSRAM_WADDR_sv, o_TPSRAM_WD, o_TPSRAM_WEN
   );
endinterface
`default_nettype wire

// File: rtl/restart_record_reader.sv
`default_nettype none
// ============================================================================
// Module   : restart_record_reader
// Brief    : Reads a 6-byte restart record from TPSRAM, checks magic and XOR
//            checksum, reports its fields. Define RESTART_RECORD_CLEAR_EN to
//            erase the magic of a valid record after reading it.
// Revision : 1.0
// ============================================================================
module restart_record_reader #(
   parameter logic [5:0] BASE_ADDR = 6'd0,
   parameter logic [7:0] MAGIC0    = 8'hA5,
   parameter logic [7:0] MAGIC1    = 8'h5A
) (
   input  wire logic              CLK,
   input  wire logic              RESETn,
   restart_record_reader_if.slave bus
);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_READ  = 3'd1;
   localparam logic [2:0] c_CHECK = 3'd2;
`ifdef RESTART_RECORD_CLEAR_EN
   localparam logic [2:0] c_CLEAR = 3'd3;
`endif
   localparam logic [2:0] c_DONE  = 3'd4;

   logic [2:0] r_state;
   logic [2:0] r_cnt;
   logic [7:0] r_byte0;
   logic [7:0] r_byte1;
   logic [7:0] r_status_cap;
   logic [7:0] r_idx_cap;
   logic [7:0] r_rcnt_cap;
   logic [7:0] r_xor;
   logic       r_valid;
   logic [7:0] r_status;
   logic [7:0] r_image_idx;
   logic [7:0] r_restart_cnt;

   logic       w_rec_ok;
   logic       w_load;
   logic       w_ren;
   logic [5:0] w_raddr;

   assign w_rec_ok = (r_byte0 == MAGIC0) && (r_byte1 == MAGIC1) && (r_xor == 8'h00);

   // Result registers are loaded on the edge that enters DONE.
`ifdef RESTART_RECORD_CLEAR_EN
   assign w_load = ((r_state == c_CHECK) && !w_rec_ok) ||
                   ((r_state == c_CLEAR) && (r_cnt == 3'd1));
`else
   assign w_load = (r_state == c_CHECK);
`endif

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_state       <= c_IDLE;
         r_cnt         <= 3'd0;
         r_byte0       <= 8'h00;
         r_byte1       <= 8'h00;
         r_status_cap  <= 8'h00;
         r_idx_cap     <= 8'h00;
         r_rcnt_cap    <= 8'h00;
         r_xor         <= 8'h00;
         r_valid       <= 1'b0;
         r_status      <= 8'h00;
         r_image_idx   <= 8'h00;
         r_restart_cnt <= 8'h00;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (bus.i_start) begin
                  r_state <= c_READ;
                  r_cnt   <= 3'd0;
                  r_xor   <= 8'h00;
               end
            end
            c_READ: begin
               // Read data lags the address by one cycle: count k holds byte k-1.
               if (r_cnt != 3'd0) begin
                  r_xor <= r_xor ^ bus.i_TPSRAM_RD_sv;
                  case (r_cnt)
                     3'd1:    r_byte0      <= bus.i_TPSRAM_RD_sv;
                     3'd2:    r_byte1      <= bus.i_TPSRAM_RD_sv;
                     3'd3:    r_status_cap <= bus.i_TPSRAM_RD_sv;
                     3'd4:    r_idx_cap    <= bus.i_TPSRAM_RD_sv;
                     3'd5:    r_rcnt_cap   <= bus.i_TPSRAM_RD_sv;
                     default: ;
                  endcase
               end
               if (r_cnt == 3'd6) begin
                  r_state <= c_CHECK;
                  r_cnt   <= 3'd0;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            c_CHECK: begin
`ifdef RESTART_RECORD_CLEAR_EN
               if (w_rec_ok) begin
                  r_state <= c_CLEAR;
                  r_cnt   <= 3'd0;
               end else begin
                  r_state <= c_DONE;
               end
`else
               r_state <= c_DONE;
`endif
            end
`ifdef RESTART_RECORD_CLEAR_EN
            c_CLEAR: begin
               if (r_cnt == 3'd1) begin
                  r_state <= c_DONE;
                  r_cnt   <= 3'd0;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
`endif
            c_DONE:  r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase

         if (w_load) begin
            r_valid       <= w_rec_ok;
            r_status      <= w_rec_ok ? r_status_cap : 8'h00;
            r_image_idx   <= w_rec_ok ? r_idx_cap    : 8'h00;
            r_restart_cnt <= w_rec_ok ? r_rcnt_cap   : 8'h00;
         end
      end
   end

   always_comb begin
      w_ren   = (r_state == c_READ) && (r_cnt != 3'd6);
      w_raddr = 6'd0;
      if (w_ren) begin
         w_raddr = BASE_ADDR + {3'b000, r_cnt};
      end
   end

   assign bus.o_TPSRAM_REN      = w_ren;
   assign bus.o_TPSRAM_RADDR_sv = w_raddr;

`ifdef RESTART_RECORD_CLEAR_EN
   logic       w_wen;
   logic [5:0] w_waddr;

   always_comb begin
      w_wen   = (r_state == c_CLEAR);
      w_waddr = 6'd0;
      if (w_wen) begin
         w_waddr = BASE_ADDR + {3'b000, r_cnt};
      end
   end

   assign bus.o_TPSRAM_WEN      = w_wen;
   assign bus.o_TPSRAM_WADDR_sv = w_waddr;
`else
   assign bus.o_TPSRAM_WEN      = 1'b0;
   assign bus.o_TPSRAM_WADDR_sv = 6'd0;
`endif
   assign bus.o_TPSRAM_WD       = 8'h00;

   assign bus.o_busy        = (r_state != c_IDLE);
   assign bus.o_done        = (r_state == c_DONE);
   assign bus.o_valid       = r_valid;
   assign bus.o_status      = r_status;
   assign bus.o_image_idx   = r_image_idx;
   assign bus.o_restart_cnt = r_restart_cnt;

endmodule
`default_nettype wire
